// File: rtl/time_keeper_pkg.sv
// rtl/time_keeper_pkg.sv - shared types, BCD limits and load-word legality check for time_keeper
package time_keeper_pkg;

  typedef enum logic [1:0] {UNSET, RUN, HOLD} state_t;

  localparam int DIGIT_W = 4;
  localparam int PAIR_W  = 8;
  localparam int HHMM_W  = 16;

  localparam logic [PAIR_W-1:0] MIN_SEC_MAX = 8'h59;
  localparam logic [PAIR_W-1:0] HOUR_MAX    = 8'h23;

  // A set word is usable only if it is a real 24-hour HH:MM in BCD.
  function automatic logic bcd_time_legal(input logic [HHMM_W-1:0] t);
    logic [DIGIT_W-1:0] ht, hu, mt, mu;
    ht = t[15:12];
    hu = t[11:8];
    mt = t[7:4];
    mu = t[3:0];
    return (ht <= 4'd2) && (hu <= 4'd9) && (mt <= 4'd5) && (mu <= 4'd9) &&
           !((ht == 4'd2) && (hu > 4'd3));
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping at MAX with load and carry out
module bcd_mod_counter
  import time_keeper_pkg::*;
#(
  parameter logic [PAIR_W-1:0] MAX = MIN_SEC_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [PAIR_W-1:0] load_value,
  output logic [PAIR_W-1:0] value,
  output logic              carry
);

  assign carry = en && (value == MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (en) begin
      if (value == MAX)
        value <= '0;
      else if (value[3:0] == 4'd9)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value <= value + 8'd1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - running HH:MM:SS clock with set/hold control; optional 12-hour display via TIME_KEEPER_12H_EN
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              load,
  input  logic [HHMM_W-1:0] load_time,
  output logic [HHMM_W-1:0] num,
  output logic [PAIR_W-1:0] sec,
  output logic              sec_tick,
  output logic              time_valid,
  output logic              load_err
`ifdef TIME_KEEPER_12H_EN
  ,
  output logic              pm
`endif
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TC = PW'(TICKS_PER_SEC - 1);

  state_t            state;
  logic [PW-1:0]     presc;
  logic              load_ok, count_en, wrap;
  logic              sec_carry, min_carry, hr_carry;
  logic [PAIR_W-1:0] sec_q, min_q, hr_q;

  assign load_ok  = load && bcd_time_legal(load_time);
  // Any load cycle, legal or not, freezes counting; a legal one restarts the second.
  assign count_en = (state != UNSET) && !hold && !load;
  assign wrap     = count_en && (presc == TC);

  bcd_mod_counter #(.MAX(MIN_SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .en(wrap), .load(load_ok),
    .load_value(8'h00), .value(sec_q), .carry(sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_SEC_MAX)) u_min (
    .clk(clk), .reset(reset), .en(sec_carry), .load(load_ok),
    .load_value(load_time[7:0]), .value(min_q), .carry(min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hr (
    .clk(clk), .reset(reset), .en(min_carry), .load(load_ok),
    .load_value(load_time[15:8]), .value(hr_q), .carry(hr_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNSET;
      presc      <= '0;
      sec_tick   <= 1'b0;
      time_valid <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      sec_tick <= wrap;
      load_err <= load && !load_ok;
      if (load_ok) begin
        state      <= RUN;
        presc      <= '0;
        time_valid <= 1'b1;
      end else if (!load) begin
        if (count_en)
          presc <= wrap ? '0 : presc + 1'b1;
        case (state)
          RUN:     if (hold) state <= HOLD;
          HOLD:    if (!hold) state <= RUN;
          default: state <= state;
        endcase
      end
    end
  end

  assign sec = sec_q;

`ifdef TIME_KEEPER_12H_EN
  logic [4:0]        h_bin, h_sub;
  logic [PAIR_W-1:0] hr_disp;

  // Midnight reads as 12, afternoon hours drop by twelve; unset time stays all zeros.
  always_comb begin
    h_bin   = 5'(hr_q[7:4]) * 5'd10 + 5'(hr_q[3:0]);
    h_sub   = h_bin - 5'd12;
    hr_disp = hr_q;
    if (time_valid) begin
      if (h_bin == 5'd0)
        hr_disp = 8'h12;
      else if (h_bin > 5'd12)
        hr_disp = (h_sub >= 5'd10) ? {4'd1, 4'(h_sub - 5'd10)} : {4'd0, 4'(h_sub)};
    end
  end

  assign num = {hr_disp, min_q};
  assign pm  = (hr_q >= 8'h12);
`else
  assign num = {hr_q, min_q};
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed bench for time_keeper with a seconds-of-day reference model
module tb_time_keeper;

  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        reset, hold, load;
  logic [15:0] load_time;
  logic [15:0] num;
  logic [7:0]  sec;
  logic        sec_tick, time_valid, load_err;
`ifdef TIME_KEEPER_12H_EN
  logic        pm;
`endif

  time_keeper #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .hold(hold), .load(load), .load_time(load_time),
    .num(num), .sec(sec), .sec_tick(sec_tick), .time_valid(time_valid),
    .load_err(load_err)
`ifdef TIME_KEEPER_12H_EN
    , .pm(pm)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ticks = 0;
  bit chk   = 0;

  // Reference: mode 0=unset 1=running 2=frozen, time as seconds since midnight.
  int m_mode = 0, m_pre = 0, m_tod = 0;
  bit m_valid = 0, m_tick = 0, m_err = 0;

  function automatic bit legal_word(input logic [15:0] w);
    int h, m;
    if (w[15:12] > 9 || w[11:8] > 9 || w[7:4] > 9 || w[3:0] > 9) return 0;
    h = w[15:12] * 10 + w[11:8];
    m = w[7:4] * 10 + w[3:0];
    return (h < 24) && (m < 60);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_num();
    int hh;
    hh = m_tod / 3600;
`ifdef TIME_KEEPER_12H_EN
    if (m_valid) hh = (hh % 12 == 0) ? 12 : hh % 12;
`endif
    return {to_bcd(hh), to_bcd((m_tod / 60) % 60)};
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_mode = 0; m_pre = 0; m_tod = 0; m_valid = 0; m_tick = 0; m_err = 0;
    end else begin
      m_tick = 0;
      m_err  = 0;
      if (load) begin
        if (legal_word(load_time)) begin
          m_tod   = (load_time[15:12] * 10 + load_time[11:8]) * 3600 +
                    (load_time[7:4] * 10 + load_time[3:0]) * 60;
          m_pre   = 0;
          m_valid = 1;
          m_mode  = 1;
        end else begin
          m_err = 1;
        end
      end else begin
        if (m_mode != 0 && !hold) begin
          m_pre++;
          if (m_pre == TPS) begin
            m_pre  = 0;
            m_tod  = (m_tod + 1) % 86400;
            m_tick = 1;
          end
        end
        if (m_mode == 1 && hold) m_mode = 2;
        else if (m_mode == 2 && !hold) m_mode = 1;
      end
    end
  endtask

  task automatic step(input int n);
    bit pm_bad;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (sec_tick === 1'b1) ticks++;
      if (chk) begin
        pm_bad = 0;
`ifdef TIME_KEEPER_12H_EN
        pm_bad = (pm !== (m_tod >= 12 * 3600));
`endif
        total++;
        if (num !== exp_num() || sec !== to_bcd(m_tod % 60) || sec_tick !== m_tick ||
            time_valid !== m_valid || load_err !== m_err || pm_bad) begin
          bad++;
          $display("FAIL model t=%0t num=%h want %h sec=%h want %h tick=%b want %b valid=%b want %b err=%b want %b pm_bad=%b",
                   $time, num, exp_num(), sec, to_bcd(m_tod % 60), sec_tick, m_tick,
                   time_valid, m_valid, load_err, m_err, pm_bad);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load      = 1'b1;
    load_time = v;
    step(1);
    load      = 1'b0;
  endtask

  initial begin
    int k, t0;
    reset = 1'b1; hold = 1'b0; load = 1'b0; load_time = 16'h0000;
    step(2);
    reset = 1'b0;
    chk   = 1;
    check("reset_num", num, 16'h0000);
    check("reset_sec", sec, 8'h00);
    check("reset_valid", time_valid, 0);
    check("reset_tick_err", {sec_tick, load_err}, 0);
    step(3);
    check("unset_idle_num", num, 16'h0000);

    do_load(16'h0938);
    check("load_num", num, 16'h0938);
    check("load_valid", time_valid, 1);
    t0 = ticks;
    step(240);
    check("count_num", num, 16'h0939);
    check("count_sec", sec, 8'h00);
    check("count_ticks", ticks - t0, 60);

    do_load(16'h0938);
    do_load(16'h2460);
    check("bad_hour_err", load_err, 1);
    check("bad_hour_num", num, 16'h0938);
    do_load(16'h0A00);
    check("bad_digit_err", load_err, 1);
    check("bad_digit_num", num, 16'h0938);
    step(1);
    check("err_one_cycle", load_err, 0);

    do_load(16'h2359);
    step(240);
`ifdef TIME_KEEPER_12H_EN
    check("day_wrap", num, 16'h1200);
`else
    check("day_wrap", num, 16'h0000);
`endif
    do_load(16'h0959);
    step(240);
    check("hour_carry", num, 16'h1000);

    do_load(16'h0100);
    k = 0;
    while (sec !== 8'h05 && k < 100) begin step(1); k++; end
    check("reach_sec5", sec, 8'h05);
    step(2);
    hold = 1'b1;
    t0 = ticks;
    step(50);
    check("hold_ticks", ticks - t0, 0);
    check("hold_sec", sec, 8'h05);
    check("hold_num", num, 16'h0100);
    hold = 1'b0;
    k = 0;
    do begin step(1); k++; end while (sec_tick !== 1'b1 && k < 10);
    check("resume_latency", k, 2);
    check("resume_sec", sec, 8'h06);

    k = 0;
    while (!(m_pre == TPS - 1 && m_mode == 1) && k < 10) begin step(1); k++; end
    check("found_terminal", m_pre, TPS - 1);
    do_load(16'h1234);
    check("collide_num", num, 16'h1234);
    check("collide_sec", sec, 8'h00);
    check("collide_tick", sec_tick, 0);

    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("midrun_reset_num", num, 16'h0000);
    check("midrun_reset_valid", time_valid, 0);
    check("midrun_reset_sec_tick", {sec, sec_tick}, 0);
    step(5);

`ifdef TIME_KEEPER_12H_EN
    do_load(16'h1305);
    check("h12_pm_num", num, 16'h0105);
    check("h12_pm_flag", pm, 1);
    do_load(16'h0000);
    check("h12_mid_num", num, 16'h1200);
    check("h12_mid_flag", pm, 0);
    step(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
